// File: rtl/u109_burst_buffer_pkg.sv
`default_nettype none
// ==========================================================================
// u109_pkg : shared state encoding, direction codes and byte-lane swap
// Rev 1.0
// ==========================================================================
package u109_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic DIR_WRITE = 1'b1;
  localparam logic DIR_READ  = 1'b0;

  // Widest word the swap helper handles; callers zero-extend and truncate.
  localparam int SWAP_MAX_W = 256;

  function automatic logic [SWAP_MAX_W-1:0] byte_swap(input logic [SWAP_MAX_W-1:0] din,
                                                     input int width);
    logic [SWAP_MAX_W-1:0] dout;
    int nb;
    dout = '0;
    nb   = width / 8;
    for (int i = 0; i < SWAP_MAX_W / 8; i++) begin
      if (i < nb) dout[8*i +: 8] = din[8*(nb-1-i) +: 8];
    end
    return dout;
  endfunction

endpackage
`default_nettype wire

// File: rtl/u109_burst_buffer_if.sv
`default_nettype none
// ==========================================================================
// u109_burst_buffer_if : CPU D-bus and PCI AD-bus signals of the burst buffer
// Rev 1.0
// ==========================================================================
interface u109_burst_buffer_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              PCIDIR;
  logic              nBEN;
  logic              nTS;
  logic              BURST;
  logic [DATA_W-1:0] D_IN;
  logic [DATA_W-1:0] D_OUT;
  logic              D_OE;
  logic              CPU_STB;
  logic              nTA;
  logic [DATA_W-1:0] AD_IN;
  logic [DATA_W-1:0] AD_OUT;
  logic              AD_OE;
  logic              nTRDY;
  logic              nIRDY;
  logic [CNT_W-1:0]  COUNT;
  logic              ABORT;

  modport slave (
    input  PCIDIR, nBEN, nTS, BURST, D_IN, CPU_STB, AD_IN, nTRDY,
    output D_OUT, D_OE, nTA, AD_OUT, AD_OE, nIRDY, COUNT, ABORT
  );

  modport master (
    output PCIDIR, nBEN, nTS, BURST, D_IN, CPU_STB, AD_IN, nTRDY,
    input  D_OUT, D_OE, nTA, AD_OUT, AD_OE, nIRDY, COUNT, ABORT
  );

endinterface
`default_nettype wire

// File: rtl/u109_burst_buffer_fifo.sv
`default_nettype none
// ==========================================================================
// u109_sync_fifo : single-clock fall-through FIFO with synchronous clear
// Rev 1.0
// ==========================================================================
module u109_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [DATA_W-1:0]      push_data_i,
  input  logic                   pop_i,
  output logic [DATA_W-1:0]      head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              w_do_push;
  logic              w_do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // A pop from empty is refused; a push into full is allowed only alongside a pop.
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/u109_burst_buffer.sv
`default_nettype none
// ==========================================================================
// u109_burst_buffer : DEPTH-entry burst FIFO between the 68040 D bus and PCI AD
// Rev 1.0
// ==========================================================================
module u109_burst_buffer
  import u109_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter bit SWAP_EN = 1'b1
) (
  input  logic                BCLK,
  input  logic                nRESET,
  u109_burst_buffer_if.slave  bus
);
  localparam int               CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_e            state_q, state_d;
  logic              dir_q, dir_d;
  logic [CNT_W-1:0]  beats_q, beats_d;
  logic [CNT_W-1:0]  cpu_cnt_q, cpu_cnt_d;
  logic [CNT_W-1:0]  pci_cnt_q, pci_cnt_d;
  logic              nta_q, nta_d;
  logic              abort_q, abort_d;

  logic [DATA_W-1:0] w_din_sw, w_adin_sw, w_push_data, w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_full, w_empty, w_active, w_wr, w_rd;
  logic              w_nirdy, w_pci_beat, w_cpu_wr, w_cpu_rd;
  logic              w_push, w_pop, w_clr;

  generate
    if (SWAP_EN) begin : g_swap
      assign w_din_sw  = DATA_W'(byte_swap(SWAP_MAX_W'(bus.D_IN), DATA_W));
      assign w_adin_sw = DATA_W'(byte_swap(SWAP_MAX_W'(bus.AD_IN), DATA_W));
    end else begin : g_straight
      assign w_din_sw  = bus.D_IN;
      assign w_adin_sw = bus.AD_IN;
    end
  endgenerate

  assign w_active = (state_q == ST_ACTIVE);
  assign w_wr     = w_active & (dir_q == DIR_WRITE);
  assign w_rd     = w_active & (dir_q == DIR_READ);

  // Initiator is ready only while PCI beats remain and the FIFO can feed/accept one.
  assign w_nirdy    = ~(w_active && (pci_cnt_q != beats_q) &&
                        ((dir_q == DIR_WRITE) ? !w_empty : !w_full));
  assign w_pci_beat = ~w_nirdy & ~bus.nTRDY & ~bus.nBEN;
  assign w_cpu_wr   = w_wr & bus.CPU_STB & ~bus.nBEN & (cpu_cnt_q != beats_q) &
                      (~w_full | w_pci_beat);
  assign w_cpu_rd   = w_rd & bus.CPU_STB & ~bus.nBEN & (cpu_cnt_q != beats_q) & ~w_empty;

  assign w_push      = w_cpu_wr | (w_rd & w_pci_beat);
  assign w_pop       = w_cpu_rd | (w_wr & w_pci_beat);
  assign w_push_data = (dir_q == DIR_WRITE) ? w_din_sw : w_adin_sw;

  u109_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i       (BCLK),
    .rst_ni      (nRESET),
    .clr_i       (w_clr),
    .push_i      (w_push),
    .push_data_i (w_push_data),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .count_o     (w_count),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    beats_d   = beats_q;
    cpu_cnt_d = cpu_cnt_q;
    pci_cnt_d = pci_cnt_q;
    abort_d   = abort_q;
    nta_d     = ~(w_cpu_wr | w_cpu_rd);
    w_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.nTS && !bus.nBEN) begin
          state_d   = ST_ACTIVE;
          dir_d     = bus.PCIDIR;
          beats_d   = bus.BURST ? DEPTH_C : ONE_C;
          cpu_cnt_d = '0;
          pci_cnt_d = '0;
          abort_d   = 1'b0;
          w_clr     = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (bus.nBEN) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
          w_clr   = 1'b1;
        end else begin
          cpu_cnt_d = cpu_cnt_q + CNT_W'(w_cpu_wr | w_cpu_rd);
          pci_cnt_d = pci_cnt_q + CNT_W'(w_pci_beat);
          if (cpu_cnt_d == beats_q && pci_cnt_d == beats_q) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge BCLK) begin
    if (!nRESET) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_READ;
      beats_q   <= '0;
      cpu_cnt_q <= '0;
      pci_cnt_q <= '0;
      nta_q     <= 1'b1;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      beats_q   <= beats_d;
      cpu_cnt_q <= cpu_cnt_d;
      pci_cnt_q <= pci_cnt_d;
      nta_q     <= nta_d;
      abort_q   <= abort_d;
    end
  end

  assign bus.D_OE   = w_rd;
  assign bus.AD_OE  = w_wr;
  assign bus.D_OUT  = (w_rd && !w_empty) ? w_head : '0;
  assign bus.AD_OUT = (w_wr && !w_empty) ? w_head : '0;
  assign bus.nTA    = nta_q;
  assign bus.nIRDY  = w_nirdy;
  assign bus.COUNT  = w_count;
  assign bus.ABORT  = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_u109_burst_buffer.sv
`default_nettype none
// ==========================================================================
// tb_u109_burst_buffer : two buffers (straight / swapped) against a queue model
// Rev 1.0
// ==========================================================================
`timescale 1ns/1ps
module tb_u109_burst_buffer;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int M_IDLE = 0;
  localparam int M_ACT  = 1;
  localparam int M_DONE = 2;

  logic clk = 1'b0;
  logic nrst, pcidir, nben, nts, burst, cpu_stb, ntrdy;
  logic [DATA_W-1:0] d_in, ad_in;
  always #5 clk = ~clk;

  u109_burst_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus0 ();
  u109_burst_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus1 ();

  assign bus0.PCIDIR = pcidir;  assign bus1.PCIDIR = pcidir;
  assign bus0.nBEN = nben;      assign bus1.nBEN = nben;
  assign bus0.nTS = nts;        assign bus1.nTS = nts;
  assign bus0.BURST = burst;    assign bus1.BURST = burst;
  assign bus0.D_IN = d_in;      assign bus1.D_IN = d_in;
  assign bus0.CPU_STB = cpu_stb; assign bus1.CPU_STB = cpu_stb;
  assign bus0.AD_IN = ad_in;    assign bus1.AD_IN = ad_in;
  assign bus0.nTRDY = ntrdy;    assign bus1.nTRDY = ntrdy;

  u109_burst_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SWAP_EN(1'b0)) dut0 (
    .BCLK(clk), .nRESET(nrst), .bus(bus0));
  u109_burst_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SWAP_EN(1'b1)) dut1 (
    .BCLK(clk), .nRESET(nrst), .bus(bus1));

  int n_total = 0;
  int n_bad   = 0;

  // Transaction-level model: a queue of raw words plus beat counts.
  int          m_state, m_beats, m_cpu, m_pci;
  bit          m_dir, m_abort, m_nta, m_fresh;
  logic [31:0] q[$];
  logic [31:0] cap_ad0[$], cap_ad1[$], cap_d0[$], cap_d1[$];
  logic [31:0] obs_d[2], obs_ad[2];
  int          ta_cnt[2];

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] sw(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic bit exp_nirdy();
    if (m_state != M_ACT || m_pci >= m_beats) return 1'b1;
    if (m_dir) return (q.size() == 0);
    return (q.size() >= DEPTH);
  endfunction

  task automatic check_dut(input int k, input logic [31:0] dout, input logic [31:0] adout,
                           input logic doe, input logic aoe, input logic nta, input logic nirdy,
                           input logic [2:0] cnt, input logic abort);
    string p;
    p = (k == 0) ? "st" : "sw";
    check_val({p, ".D_OE"},  64'(doe),   64'(m_state == M_ACT && !m_dir));
    check_val({p, ".AD_OE"}, 64'(aoe),   64'(m_state == M_ACT && m_dir));
    check_val({p, ".nTA"},   64'(nta),   64'(m_nta));
    check_val({p, ".nIRDY"}, 64'(nirdy), 64'(exp_nirdy()));
    check_val({p, ".COUNT"}, 64'(cnt),   64'(q.size()));
    check_val({p, ".ABORT"}, 64'(abort), 64'(m_abort));
    if (m_state == M_ACT && q.size() > 0) begin
      if (m_dir) check_val({p, ".AD_OUT"}, 64'(adout), 64'((k == 0) ? q[0] : sw(q[0])));
      else       check_val({p, ".D_OUT"},  64'(dout),  64'((k == 0) ? q[0] : sw(q[0])));
    end
    if (m_fresh) begin
      check_val({p, ".D_OUT_rst"},  64'(dout),  64'd0);
      check_val({p, ".AD_OUT_rst"}, 64'(adout), 64'd0);
    end
    if (nta === 1'b0) ta_cnt[k]++;
    obs_d[k]  = dout;
    obs_ad[k] = adout;
  endtask

  task automatic check_outputs();
    check_dut(0, bus0.D_OUT, bus0.AD_OUT, bus0.D_OE, bus0.AD_OE, bus0.nTA, bus0.nIRDY,
              bus0.COUNT, bus0.ABORT);
    check_dut(1, bus1.D_OUT, bus1.AD_OUT, bus1.D_OE, bus1.AD_OE, bus1.nTA, bus1.nIRDY,
              bus1.COUNT, bus1.ABORT);
  endtask

  task automatic model_step();
    bit nirdy_e, pci_beat, push, pop;
    if (!nrst) begin
      m_state = M_IDLE; m_dir = 1'b0; m_beats = 0; m_cpu = 0; m_pci = 0;
      q.delete(); m_abort = 1'b0; m_nta = 1'b1; m_fresh = 1'b1;
      return;
    end
    nirdy_e = exp_nirdy();
    m_nta   = 1'b1;
    case (m_state)
      M_IDLE: if (!nts && !nben) begin
        m_state = M_ACT; m_dir = pcidir; m_beats = burst ? DEPTH : 1;
        m_cpu = 0; m_pci = 0; q.delete(); m_abort = 1'b0; m_fresh = 1'b0;
      end
      M_DONE: m_state = M_IDLE;
      default: begin
        if (nben) begin
          m_state = M_IDLE; q.delete(); m_abort = 1'b1;
        end else begin
          pci_beat = !nirdy_e && !ntrdy;
          if (m_dir) begin
            pop  = pci_beat;
            push = cpu_stb && m_cpu < m_beats && (q.size() < DEPTH || pop);
            if (pop) begin
              cap_ad0.push_back(obs_ad[0]); cap_ad1.push_back(obs_ad[1]);
              void'(q.pop_front()); m_pci++;
            end
            if (push) begin q.push_back(d_in); m_cpu++; m_nta = 1'b0; end
          end else begin
            pop  = cpu_stb && m_cpu < m_beats && q.size() > 0;
            push = pci_beat;
            if (pop) begin
              cap_d0.push_back(obs_d[0]); cap_d1.push_back(obs_d[1]);
              void'(q.pop_front()); m_cpu++; m_nta = 1'b0;
            end
            if (push) begin q.push_back(ad_in); m_pci++; end
          end
          if (m_cpu == m_beats && m_pci == m_beats) m_state = M_DONE;
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n;
    n = 0;
    while (m_state != M_IDLE && n < bound) begin
      d_in = $urandom;
      tick();
      n++;
    end
    if (m_state != M_IDLE) check_val({tag, ".timeout"}, 64'd0, 64'd1);
  endtask

  task automatic clear_caps();
    cap_ad0.delete(); cap_ad1.delete(); cap_d0.delete(); cap_d1.delete();
    ta_cnt[0] = 0; ta_cnt[1] = 0;
  endtask

  task automatic start_txn(input logic dir, input logic bst);
    pcidir = dir; burst = bst; nben = 1'b0; nts = 1'b0; cpu_stb = 1'b0; ntrdy = 1'b1;
    tick();
    nts = 1'b1;
  endtask

  task automatic run_write_burst();
    logic [31:0] w[4];
    logic [31:0] ws[4];
    w[0] = 32'hffff0000; w[1] = 32'heeee1111; w[2] = 32'hdddd2222; w[3] = 32'hcccc3333;
    ws[0] = 32'h0000ffff; ws[1] = 32'h1111eeee; ws[2] = 32'h2222dddd; ws[3] = 32'h3333cccc;
    clear_caps();
    start_txn(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cpu_stb = 1'b1; d_in = w[i]; ntrdy = (i < 2) ? 1'b1 : 1'b0;
      tick();
    end
    cpu_stb = 1'b0; ntrdy = 1'b0;
    wait_idle(20, "wr");
    check_val("wr.beats", 64'(cap_ad0.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < cap_ad0.size()) check_val("wr.ad_st", 64'(cap_ad0[i]), 64'(w[i]));
      if (i < cap_ad1.size()) check_val("wr.ad_sw", 64'(cap_ad1[i]), 64'(ws[i]));
    end
    check_val("wr.ta_st", 64'(ta_cnt[0]), 64'd4);
    check_val("wr.ta_sw", 64'(ta_cnt[1]), 64'd4);
  endtask

  task automatic run_read_burst();
    logic [31:0] r[4];
    r[0] = 32'h01020304; r[1] = 32'ha0b0c0d0; r[2] = 32'h5566aa99; r[3] = 32'hdeadbeef;
    clear_caps();
    start_txn(1'b0, 1'b1);
    ntrdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ad_in = r[(m_pci < 4) ? m_pci : 3];
      tick();
    end
    check_val("rd.full_cnt", 64'(bus0.COUNT), 64'd4);
    check_val("rd.full_irdy", 64'(bus1.nIRDY), 64'd1);
    ntrdy = 1'b1; cpu_stb = 1'b1;
    wait_idle(20, "rd");
    cpu_stb = 1'b0;
    check_val("rd.beats", 64'(cap_d0.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < cap_d0.size()) check_val("rd.d_st", 64'(cap_d0[i]), 64'(r[i]));
      if (i < cap_d1.size()) check_val("rd.d_sw", 64'(cap_d1[i]), 64'(sw(r[i])));
    end
    check_val("rd.ta", 64'(ta_cnt[0]), 64'd4);
    check_val("rd.cnt_end", 64'(bus1.COUNT), 64'd0);
  endtask

  task automatic run_single();
    clear_caps();
    start_txn(1'b1, 1'b0);
    cpu_stb = 1'b1; d_in = 32'h12345678; ntrdy = 1'b1;
    tick();
    d_in = 32'h9abcdef0; ntrdy = 1'b0;
    tick();
    cpu_stb = 1'b0;
    tick();
    check_val("single.beats", 64'(cap_ad0.size()), 64'd1);
    if (cap_ad0.size() > 0) check_val("single.ad_st", 64'(cap_ad0[0]), 64'h12345678);
    if (cap_ad1.size() > 0) check_val("single.ad_sw", 64'(cap_ad1[0]), 64'h78563412);
    check_val("single.ta", 64'(ta_cnt[1]), 64'd1);
  endtask

  task automatic run_abort();
    start_txn(1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cpu_stb = 1'b1; d_in = $urandom; ntrdy = 1'b1;
      tick();
    end
    cpu_stb = 1'b0; nben = 1'b1;
    tick();
    check_val("abort.cnt", 64'(bus0.COUNT), 64'd0);
    check_val("abort.flag", 64'(bus1.ABORT), 64'd1);
    check_val("abort.oe", 64'({bus0.AD_OE, bus1.AD_OE}), 64'd0);
    start_txn(1'b1, 1'b1);
    check_val("abort.clear", 64'(bus0.ABORT), 64'd0);
    cpu_stb = 1'b1; ntrdy = 1'b0;
    wait_idle(20, "abort");
    cpu_stb = 1'b0;
  endtask

  task automatic run_reset_mid();
    start_txn(1'b1, 1'b1);
    cpu_stb = 1'b1; d_in = $urandom; ntrdy = 1'b1;
    tick();
    tick();
    nrst = 1'b0; cpu_stb = 1'b0;
    tick();
    nrst = 1'b1;
    tick();
    run_write_burst();
  endtask

  task automatic run_random(input int n_txn);
    int cyc;
    for (int t = 0; t < n_txn; t++) begin
      start_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cyc = 0;
      while (m_state != M_IDLE && cyc < 60) begin
        cpu_stb = ($urandom_range(0, 99) < 60);
        ntrdy   = ($urandom_range(0, 99) < 40);
        nts     = 1'($urandom_range(0, 1));
        d_in    = $urandom;
        ad_in   = $urandom;
        nben    = ($urandom_range(0, 99) < 2);
        nrst    = ($urandom_range(0, 199) != 0);
        tick();
        nrst = 1'b1; nben = 1'b0;
        cyc++;
      end
      if (m_state != M_IDLE) check_val("rand.timeout", 64'd0, 64'd1);
    end
  endtask

  initial begin
    nrst = 1'b0; pcidir = 1'b0; nben = 1'b1; nts = 1'b1; burst = 1'b0;
    cpu_stb = 1'b0; ntrdy = 1'b1; d_in = '0; ad_in = '0;
    m_state = M_IDLE; m_nta = 1'b1; m_fresh = 1'b1;
    @(negedge clk);
    tick();
    nrst = 1'b1;
    tick();
    run_write_burst();
    run_read_burst();
    run_single();
    run_abort();
    run_reset_mid();
    run_random(40);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
